tea_round_sequencer: RTL and testbench
======================================

Name: tea_round_sequencer

Overview:
Control and datapath stage that sits directly upstream of the 8-bit logic block (ALU). It runs an 8-bit Tiny Encryption Algorithm encryption on a two-byte block {v0,v1} under a four-byte key. Each cycle it drives the ALU's operand and opcode inputs with one micro-op and writes the ALU's combinational result back into its own registers. It also provides a start/busy/done handshake toward the host.

Parameters:
ROUNDS, 32, number of TEA rounds per block; legal range 1..255.
DELTA_OP, 3'b110, ALU opcode that yields the delta constant (8'hE0).

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  reset, asynchronous and active-low.
start  input  1  one-cycle request; sampled only when idle.
din_v0  input  8  plaintext byte v0; sampled with start.
din_v1  input  8  plaintext byte v1; sampled with start.
key  input  32  {k3,k2,k1,k0}, k0 = key[7:0]; sampled with start.
busy  output  1  high while encryption is in progress.
done  output  1  one-cycle pulse when the result is valid.
dout_v0  output  8  ciphertext v0; held until the next start is accepted.
dout_v1  output  8  ciphertext v1; held until the next start is accepted.
alu_num1  output  8  ALU operand 1.
alu_num2  output  8  ALU operand 2.
alu_op  output  3  ALU opcode: 000 pass, 001 <<4, 010 >>5, 011 add, 100 sub, 101 xor, 110 const E0.
alu_result  input  8  combinational ALU result for the current cycle.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; busy=0; done=0; dout_v0/dout_v1=0; alu_num1/alu_num2=0; alu_op=000. Internal v0, v1, sum, t0, t1, step, and round registers all clear.
- Reset asserted mid-operation aborts the block immediately. No done pulse is issued.
- States are IDLE, RUN, and DONE.
- IDLE: if start=1 at a clock edge, capture din_v0, din_v1, and key; clear sum, step, and round; go to RUN. busy rises at that same edge.
- start while busy or done is high is ignored.
- RUN executes 18 micro-ops per round, one per cycle, with step running 0..17. The ALU result is written at the end of each cycle.
  - step 0: t1 = const (op 110).
  - step 1: sum = sum + t1.
  - Half A, steps 2..9, with x=v1, ka=k0, kb=k1, dst=v0:
    - t0 = x<<4
    - t0 = t0+ka
    - t1 = x+sum
    - t0 = t0^t1
    - t1 = x>>5
    - t1 = t1+kb
    - t0 = t0^t1
    - dst = dst+t0
  - Half B, steps 10..17: same eight micro-ops with x=v0 (already updated), ka=k2, kb=k3, dst=v1.
- After step 17: step returns to 0 and round increments. When round reaches ROUNDS, go to DONE.
- In DONE, for one cycle: done=1, busy=0, dout_v0=v0, dout_v1=v1. Then return to IDLE.
- Latency: if start is accepted at edge N, done is high during the cycle following edge N+18*ROUNDS.
- Arithmetic is modulo 256 with no carry out. Shifts are logical; bits shifted out are lost.
- sum wraps freely: after round r, sum = (r*8'hE0) mod 256.
- Outside RUN, alu_op=000 and both operands are 0. The ALU result is ignored.

Test Plan:
- Reset: hold rst_n=0 -> busy=0, done=0, dout=00/00, alu_op=000. Release, idle 5 cycles -> outputs unchanged.
- ROUNDS=1, v0=00, v1=00, key=0 -> done after 18 cycles; dout_v0=E0, dout_v1=C7.
- ROUNDS=1, v0=01, v1=02, key=32'h04030201 -> dout_v0=C2, dout_v1=8D. Check the alu_op sequence 110,011,001,011,011,101,010,011,101,011, and so on.
- ROUNDS=32, any vector -> busy high for exactly 576 cycles; exactly one done pulse; sum=00 at the end. Result matches the reference model.
- Pulse start at cycle 100 of a run -> ignored; result and timing identical to an undisturbed run.
- Drop rst_n at step 9 of round 3 -> busy=0 immediately, no done. A new start then runs a clean, correct encryption.

Source files
------------

// File: rtl/tea_round_sequencer.sv
`default_nettype none
// ============================================================================
// tea_round_sequencer : 8-bit TEA encryption sequencer. Issues one micro-op per
// cycle to an external 8-bit ALU and writes its result back into local state.
// Revision 1.0
// ============================================================================
module tea_round_sequencer #(
  parameter int unsigned ROUNDS   = 32,
  parameter logic [2:0]  DELTA_OP = 3'b110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  din_v0,
  input  logic [7:0]  din_v1,
  input  logic [31:0] key,
  output logic        busy,
  output logic        done,
  output logic [7:0]  dout_v0,
  output logic [7:0]  dout_v1,
  output logic [7:0]  alu_num1,
  output logic [7:0]  alu_num2,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_result
);

  localparam logic [2:0] OP_PASS    = 3'b000;
  localparam logic [2:0] OP_SHL4    = 3'b001;
  localparam logic [2:0] OP_SHR5    = 3'b010;
  localparam logic [2:0] OP_ADD     = 3'b011;
  localparam logic [2:0] OP_XOR     = 3'b101;
  localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);
  localparam logic [4:0] LAST_STEP  = 5'd17;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {WR_NONE, WR_T0, WR_T1, WR_SUM, WR_V0, WR_V1} wr_t;

  state_t      state_q, state_d;
  logic [7:0]  v0_q, v0_d, v1_q, v1_d, sum_q, sum_d, t0_q, t0_d, t1_q, t1_d;
  logic [7:0]  dout_v0_q, dout_v0_d, dout_v1_q, dout_v1_d;
  logic [4:0]  step_q, step_d;
  logic [7:0]  round_q, round_d;
  logic [31:0] key_q, key_d;

  logic        half_b;
  logic [2:0]  idx;
  logic [7:0]  x, ka, kb;
  wr_t         wr;

  // Steps 2..9 and 10..17 share the same eight-op pattern; low 3 bits of step-2 index it.
  always_comb begin
    half_b   = (step_q >= 5'd10);
    idx      = 3'(step_q - 5'd2);
    x        = half_b ? v0_q : v1_q;
    ka       = half_b ? key_q[23:16] : key_q[7:0];
    kb       = half_b ? key_q[31:24] : key_q[15:8];
    alu_op   = OP_PASS;
    alu_num1 = '0;
    alu_num2 = '0;
    wr       = WR_NONE;
    if (state_q == RUN) begin
      if (step_q == 5'd0) begin
        alu_op = DELTA_OP;
        wr     = WR_T1;
      end else if (step_q == 5'd1) begin
        alu_op   = OP_ADD;
        alu_num1 = sum_q;
        alu_num2 = t1_q;
        wr       = WR_SUM;
      end else begin
        case (idx)
          3'd0: begin alu_op = OP_SHL4; alu_num1 = x;                     wr = WR_T0; end
          3'd1: begin alu_op = OP_ADD;  alu_num1 = t0_q; alu_num2 = ka;   wr = WR_T0; end
          3'd2: begin alu_op = OP_ADD;  alu_num1 = x;    alu_num2 = sum_q; wr = WR_T1; end
          3'd3: begin alu_op = OP_XOR;  alu_num1 = t0_q; alu_num2 = t1_q; wr = WR_T0; end
          3'd4: begin alu_op = OP_SHR5; alu_num1 = x;                     wr = WR_T1; end
          3'd5: begin alu_op = OP_ADD;  alu_num1 = t1_q; alu_num2 = kb;   wr = WR_T1; end
          3'd6: begin alu_op = OP_XOR;  alu_num1 = t0_q; alu_num2 = t1_q; wr = WR_T0; end
          default: begin
            alu_op   = OP_ADD;
            alu_num1 = half_b ? v1_q : v0_q;
            alu_num2 = t0_q;
            wr       = half_b ? WR_V1 : WR_V0;
          end
        endcase
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    v0_d      = v0_q;
    v1_d      = v1_q;
    sum_d     = sum_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
    step_d    = step_q;
    round_d   = round_q;
    key_d     = key_q;
    dout_v0_d = dout_v0_q;
    dout_v1_d = dout_v1_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          v0_d    = din_v0;
          v1_d    = din_v1;
          key_d   = key;
          sum_d   = '0;
          step_d  = '0;
          round_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        case (wr)
          WR_T0:   t0_d  = alu_result;
          WR_T1:   t1_d  = alu_result;
          WR_SUM:  sum_d = alu_result;
          WR_V0:   v0_d  = alu_result;
          WR_V1:   v1_d  = alu_result;
          default: ;
        endcase
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          round_d = round_q + 8'd1;
          if (round_q == LAST_ROUND) state_d = DONE;
        end else begin
          step_d = step_q + 5'd1;
        end
      end
      DONE: begin
        dout_v0_d = v0_q;
        dout_v1_d = v1_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      v0_q      <= '0;
      v1_q      <= '0;
      sum_q     <= '0;
      t0_q      <= '0;
      t1_q      <= '0;
      step_q    <= '0;
      round_q   <= '0;
      key_q     <= '0;
      dout_v0_q <= '0;
      dout_v1_q <= '0;
    end else begin
      state_q   <= state_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      sum_q     <= sum_d;
      t0_q      <= t0_d;
      t1_q      <= t1_d;
      step_q    <= step_d;
      round_q   <= round_d;
      key_q     <= key_d;
      dout_v0_q <= dout_v0_d;
      dout_v1_q <= dout_v1_d;
    end
  end

  // The result must be visible during the done cycle itself, then held by the register.
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign dout_v0 = done ? v0_q : dout_v0_q;
  assign dout_v1 = done ? v1_q : dout_v1_q;

endmodule
`default_nettype wire

// File: tb/tb_tea_round_sequencer.sv
`default_nettype none
// ============================================================================
// tb_tea_round_sequencer : bench for the TEA sequencer with a behavioural ALU,
// two instances (1 round and 32 rounds) and a result scoreboard.
// Revision 1.0
// ============================================================================
module tb_tea_round_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start32;
  logic [7:0]  din_v0, din_v1;
  logic [31:0] key;

  logic       busy_1, done_1, busy_32, done_32;
  logic [7:0] dv0_1, dv1_1, n1_1, n2_1, res_1;
  logic [7:0] dv0_32, dv1_32, n1_32, n2_32, res_32;
  logic [2:0] op_1, op_32;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [7:0] r;
    case (op)
      3'b000:  r = a;
      3'b001:  r = a << 4;
      3'b010:  r = a >> 5;
      3'b011:  r = a + b;
      3'b100:  r = a - b;
      3'b101:  r = a ^ b;
      3'b110:  r = 8'hE0;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign res_1  = alu(n1_1, n2_1, op_1);
  assign res_32 = alu(n1_32, n2_32, op_32);

  tea_round_sequencer #(.ROUNDS(1), .DELTA_OP(3'b110)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .din_v0(din_v0), .din_v1(din_v1), .key(key),
    .busy(busy_1), .done(done_1), .dout_v0(dv0_1), .dout_v1(dv1_1),
    .alu_num1(n1_1), .alu_num2(n2_1), .alu_op(op_1), .alu_result(res_1));

  tea_round_sequencer #(.ROUNDS(32), .DELTA_OP(3'b110)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .din_v0(din_v0), .din_v1(din_v1), .key(key),
    .busy(busy_32), .done(done_32), .dout_v0(dv0_32), .dout_v1(dv1_32),
    .alu_num1(n1_32), .alu_num2(n2_32), .alu_op(op_32), .alu_result(res_32));

  function automatic logic [15:0] ref_enc(input logic [7:0] a, input logic [7:0] b,
                                          input logic [31:0] k, input int r);
    logic [7:0] y, z, s, p, q, u;
    y = a; z = b; s = 8'h00;
    for (int i = 0; i < r; i++) begin
      s = s + 8'hE0;
      p = z << 4;  p = p + k[7:0];
      q = z + s;
      u = z >> 5;  u = u + k[15:8];
      y = y + (p ^ q ^ u);
      p = y << 4;  p = p + k[23:16];
      q = y + s;
      u = y >> 5;  u = u + k[31:24];
      z = z + (p ^ q ^ u);
    end
    return {y, z};
  endfunction

  function automatic logic [2:0] op_for(input int s);
    logic [2:0] half_ops [8];
    half_ops = '{3'b001, 3'b011, 3'b011, 3'b101, 3'b010, 3'b011, 3'b101, 3'b011};
    if (s == 0) return 3'b110;
    if (s == 1) return 3'b011;
    return half_ops[(s - 2) % 8];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_block(input bit big, input logic [7:0] a, input logic [7:0] b,
                           input logic [31:0] k, input int disturb_at, input int abort_at,
                           input bit chk_ops);
    int         r;
    int         cycles;
    int         iter;
    bit         seen;
    bit         late_done;
    logic [15:0] exp;
    r = big ? 32 : 1;
    cycles = 0; iter = 0; seen = 0; late_done = 0;
    sb_q.push_back(ref_enc(a, b, k, r));
    @(posedge clk); #1;
    din_v0 = a; din_v1 = b; key = k;
    if (big) start32 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start32 = 1'b0;
    while (iter < 18 * r + 20) begin
      if (big ? done_32 : done_1) begin
        seen = 1;
        break;
      end
      if (big && cycles == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy_32}, 32'd0);
        check("abort_done", {31'd0, done_32}, 32'd0);
        void'(sb_q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
          if (done_32) late_done = 1;
          @(posedge clk); #1;
        end
        check("abort_no_done", {31'd0, late_done}, 32'd0);
        return;
      end
      if (big ? busy_32 : busy_1) begin
        if (chk_ops && cycles < 18)
          check($sformatf("op_step%0d", cycles), {29'd0, (big ? op_32 : op_1)}, {29'd0, op_for(cycles)});
        cycles++;
      end
      if (big && cycles == disturb_at) begin
        start32 = 1'b1; din_v0 = ~a; din_v1 = ~b; key = ~k;
      end else begin
        start32 = 1'b0;
      end
      iter++;
      @(posedge clk); #1;
    end
    start32 = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      exp = sb_q.pop_front();
      check("dout_v0", {24'd0, (big ? dv0_32 : dv0_1)}, {24'd0, exp[15:8]});
      check("dout_v1", {24'd0, (big ? dv1_32 : dv1_1)}, {24'd0, exp[7:0]});
      check("busy_cycles", cycles, 18 * r);
      check("busy_at_done", {31'd0, (big ? busy_32 : busy_1)}, 32'd0);
      if (big) check("sum_final", {24'd0, dut32.sum_q}, 32'd0);
      @(posedge clk); #1;
      check("done_single", {31'd0, (big ? done_32 : done_1)}, 32'd0);
      check("dout_held_v0", {24'd0, (big ? dv0_32 : dv0_1)}, {24'd0, exp[15:8]});
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy1"}, {31'd0, busy_1}, 32'd0);
    check({tag, "_done1"}, {31'd0, done_1}, 32'd0);
    check({tag, "_dout1"}, {16'd0, dv0_1, dv1_1}, 32'd0);
    check({tag, "_alu1"}, {13'd0, op_1, n1_1, n2_1}, 32'd0);
    check({tag, "_busy32"}, {31'd0, busy_32}, 32'd0);
    check({tag, "_done32"}, {31'd0, done_32}, 32'd0);
    check({tag, "_dout32"}, {16'd0, dv0_32, dv1_32}, 32'd0);
    check({tag, "_alu32"}, {13'd0, op_32, n1_32, n2_32}, 32'd0);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [31:0] rk;
    rst_n = 1'b0; start1 = 1'b0; start32 = 1'b0;
    din_v0 = 8'h00; din_v1 = 8'h00; key = 32'h0;
    #12;
    check_idle("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_idle("idle");

    run_block(1'b0, 8'h00, 8'h00, 32'h0, -1, -1, 1'b0);
    check("zero_v0", {24'd0, dv0_1}, 32'hE0);
    check("zero_v1", {24'd0, dv1_1}, 32'hC7);

    run_block(1'b0, 8'h01, 8'h02, 32'h04030201, -1, -1, 1'b1);
    check("vec2_v0", {24'd0, dv0_1}, 32'hC2);
    check("vec2_v1", {24'd0, dv1_1}, 32'h8D);

    ra = 8'($urandom); rb = 8'($urandom); rk = $urandom;
    run_block(1'b1, ra, rb, rk, -1, -1, 1'b1);

    run_block(1'b1, 8'h5A, 8'hC3, 32'hDEADBEEF, 100, -1, 1'b0);

    run_block(1'b1, 8'h11, 8'h22, 32'h33445566, -1, 63, 1'b0);
    run_block(1'b1, 8'h11, 8'h22, 32'h33445566, -1, -1, 1'b0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
